// File: rtl/timer_device_pkg.sv
// Shared constants for the DEV0 timer: register offsets, CTRL bit layout, MODE and FSM encodings.
// Optional prescaler is enabled with the TIMER_PRESCALE_EN macro (see timer_device.sv).
package timer_device_pkg;

    typedef logic [1:0] reg_off_t;
    typedef logic [1:0] state_t;

    localparam logic [31:0] DEV_BASE = 32'h0000_7F00;
    localparam logic [31:0] DEV_LAST = 32'h0000_7F0F;

    localparam reg_off_t OFF_CTRL   = 2'b00;
    localparam reg_off_t OFF_PRESET = 2'b01;
    localparam reg_off_t OFF_COUNT  = 2'b10;
    localparam reg_off_t OFF_RSVD   = 2'b11;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_PSC_LO  = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_CNT  = 2'd2;
    localparam state_t ST_INT  = 2'd3;

endpackage

// File: rtl/timer_device_if.sv
// Bridge-side bus of the timer: word address, write strobe/data, read data and IRQ.
interface timer_device_if;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (output Addr, WE, Din, input Dout, IRQ);
    modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_device.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a level IRQ.
// Define TIMER_PRESCALE_EN to add the CTRL prescale field and prescale counter.
module timer_device
    import timer_device_pkg::*;
#(
    parameter logic [31:0] RESET_PRESET = 32'h0000_0000,
    parameter int          PRESCALE_W   = 8
) (
    input  logic           clk,
    input  logic           reset,
    timer_device_if.slave  bus
);

`ifdef TIMER_PRESCALE_EN
    localparam logic [31:0] CTRL_WMASK =
        32'h0000_000F | (((32'd1 << PRESCALE_W) - 32'd1) << CTRL_PSC_LO);
`else
    localparam logic [31:0] CTRL_WMASK = 32'h0000_000F;
`endif

    logic [31:0] ctrl, preset, count;
    state_t      state;
    logic        irq_flag;
    reg_off_t    sel;
    logic        ctrl_wr, preset_wr, reload, tick;
    logic        unused_addr;

    // Addr carries byte-address bits [31:2]; bits [3:2] land at Addr[1:0]
    assign sel         = bus.Addr[1:0];
    assign unused_addr = ^bus.Addr[29:2];
    assign ctrl_wr     = bus.WE && (sel == OFF_CTRL);
    assign preset_wr   = bus.WE && (sel == OFF_PRESET);
    assign reload      = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] psc;

    assign tick = (psc == ctrl[CTRL_PSC_LO +: PRESCALE_W]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            psc <= '0;
        else if (state == ST_LOAD)
            psc <= '0;
        else if (state == ST_CNT && ctrl[CTRL_EN])
            psc <= tick ? '0 : psc + PRESCALE_W'(1);
    end
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl     <= '0;
            preset   <= RESET_PRESET;
            count    <= '0;
            state    <= ST_IDLE;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (ctrl[CTRL_EN]) state <= ST_LOAD;
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl[CTRL_EN]) begin
                        state <= ST_IDLE;
                    end else if (tick) begin
                        if (count > 32'd1) begin
                            count <= count - 32'd1;
                        end else begin
                            count    <= '0;
                            irq_flag <= 1'b1;
                            state    <= ST_INT;
                        end
                    end
                end
                ST_INT: begin
                    if (reload) begin
                        irq_flag <= 1'b0;
                        state    <= ST_LOAD;
                    end else begin
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A CPU write to CTRL overrides the one-shot EN clear and drops any pending IRQ
            if (ctrl_wr) begin
                ctrl     <= bus.Din & CTRL_WMASK;
                irq_flag <= 1'b0;
            end else if (state == ST_INT && !reload) begin
                ctrl[CTRL_EN] <= 1'b0;
            end

            if (preset_wr)
                preset <= bus.Din;
        end
    end

    always_comb begin
        bus.Dout = '0;
        case (sel)
            OFF_CTRL:   bus.Dout = ctrl;
            OFF_PRESET: bus.Dout = preset;
            OFF_COUNT:  bus.Dout = count;
            default:    bus.Dout = '0;
        endcase
    end

    assign bus.IRQ = irq_flag & ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_device.sv
// Directed self-checking bench for timer_device (expects default build unless TIMER_PRESCALE_EN is defined).
module tb_timer_device;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [31:0] rd_val;
    int   lat;

    timer_device_if bus ();

    timer_device dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.Addr = addr[31:2];
        bus.Din  = data;
        bus.WE   = 1'b1;
        @(posedge clk);
        #1;
        bus.WE   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        bus.Addr = addr[31:2];
        #1;
        data = bus.Dout;
    endtask

    initial begin
        reset    = 1'b1;
        bus.WE   = 1'b0;
        bus.Addr = '0;
        bus.Din  = '0;
        step(2);
        chk("rst_irq_init", 32'(bus.IRQ), 32'd0);
        rd(32'h7F00, rd_val); chk("rst_ctrl_init", rd_val, 32'h0);
        reset = 1'b0;

        // reset with IRQ pending: PRESET=2 one-shot, IRQ at E4
        wr(32'h7F04, 32'd2);
        wr(32'h7F00, 32'h9);
        step(4);
        chk("pend_irq", 32'(bus.IRQ), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_irq", 32'(bus.IRQ), 32'd0);
        rd(32'h7F00, rd_val); chk("rst_ctrl", rd_val, 32'h0);
        rd(32'h7F04, rd_val); chk("rst_preset", rd_val, 32'h0);
        rd(32'h7F08, rd_val); chk("rst_count", rd_val, 32'h0);
        step(1);
        chk("rst_irq_hold", 32'(bus.IRQ), 32'd0);
        reset = 1'b0;
        step(1);

        // one-shot PRESET=5
        wr(32'h7F04, 32'd5);
        wr(32'h7F00, 32'h9);
        step(2);
        rd(32'h7F08, rd_val); chk("os_count_e2", rd_val, 32'd5);
        step(4);
        chk("os_irq_e6", 32'(bus.IRQ), 32'd0);
        rd(32'h7F08, rd_val); chk("os_count_e6", rd_val, 32'd1);
        step(1);
        chk("os_irq_e7", 32'(bus.IRQ), 32'd1);
        step(1);
        rd(32'h7F00, rd_val); chk("os_ctrl_e8", rd_val, 32'h8);
        step(3);
        chk("os_irq_hold", 32'(bus.IRQ), 32'd1);
        wr(32'h7F00, 32'h8);
        chk("os_irq_clr", 32'(bus.IRQ), 32'd0);

        // auto-reload PRESET=3: IRQ pulses at E5,E10,E15,E20
        wr(32'h7F04, 32'd3);
        wr(32'h7F00, 32'hB);
        bus.Addr = 30'(32'h7F08 >> 2);
        for (int k = 1; k <= 21; k++) begin
            step(1);
            chk($sformatf("ar_irq_e%0d", k), 32'(bus.IRQ),
                (k >= 5 && (k - 5) % 5 == 0) ? 32'd1 : 32'd0);
            if (k >= 2 && k <= 6) begin
                rd(32'h7F08, rd_val);
                chk($sformatf("ar_count_e%0d", k), rd_val, (k <= 4) ? 32'(5 - k) : 32'd0);
            end
        end
        wr(32'h7F00, 32'h0);
        step(2);

        // one-shot PRESET=10, disable mid-count
        wr(32'h7F04, 32'd10);
        wr(32'h7F00, 32'h9);
        step(5);
        rd(32'h7F08, rd_val); chk("dis_count_e5", rd_val, 32'd7);
        wr(32'h7F00, 32'h8);
        rd(32'h7F08, rd_val); chk("dis_count_e6", rd_val, 32'd6);
        step(4);
        rd(32'h7F08, rd_val); chk("dis_count_hold", rd_val, 32'd6);
        chk("dis_irq", 32'(bus.IRQ), 32'd0);
        wr(32'h7F00, 32'h9);
        step(2);
        rd(32'h7F08, rd_val); chk("dis_reload", rd_val, 32'd10);
        wr(32'h7F00, 32'h0);
        step(3);

        // ignored writes, mid-count PRESET change, IM=0
        wr(32'h7F04, 32'd4);
        wr(32'h7F00, 32'h3);
        wr(32'h7F08, 32'hDEAD_0000);
        wr(32'h7F0C, 32'hBEEF_0000);
        rd(32'h7F08, rd_val); chk("ign_count_e2", rd_val, 32'd4);
        rd(32'h7F0C, rd_val); chk("rsvd_read", rd_val, 32'h0);
        wr(32'h7F04, 32'd2);
        rd(32'h7F08, rd_val); chk("pre_mid_count", rd_val, 32'd3);
        rd(32'h7F04, rd_val); chk("pre_mid_preset", rd_val, 32'd2);
        step(3);
        rd(32'h7F08, rd_val); chk("im0_count_e6", rd_val, 32'd0);
        chk("im0_irq", 32'(bus.IRQ), 32'd0);
        step(2);
        rd(32'h7F08, rd_val); chk("pre_next_load", rd_val, 32'd2);
        wr(32'h7F00, 32'h0);
        step(3);

        // prescale P=2, PRESET=4
        wr(32'h7F04, 32'd4);
        wr(32'h7F00, 32'h29);
`ifdef TIMER_PRESCALE_EN
        rd(32'h7F00, rd_val); chk("psc_field", (rd_val >> 4) & 32'hFF, 32'd2);
`else
        rd(32'h7F00, rd_val); chk("psc_field", (rd_val >> 4) & 32'hFF, 32'd0);
`endif
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (bus.IRQ) begin
                lat = k;
                break;
            end
        end
`ifdef TIMER_PRESCALE_EN
        chk("psc_latency", 32'(lat), 32'd14);
`else
        chk("psc_latency", 32'(lat), 32'd6);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
